byte_ram_master: RTL
====================

BYTE_RAM_MASTER -- requirements
Module: byte_ram_master

Interface
REQ-001 Parameter ADDR_W, default 3, SHALL be the word-address width; the RAM holds 2**ADDR_W words.
REQ-002 Parameter HOLD_CYC, default 4, SHALL be the idle cycles a pending half-word waits before being flushed.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  req_valid  in  1  byte request valid
  req_ready  out  1  block accepts the request this cycle
  req_write  in  1  1 = byte write, 0 = byte read
  req_addr  in  ADDR_W+1  byte address; [ADDR_W:1] = word, [0] = lane
  req_wdata  in  8  write byte
  rsp_valid  out  1  one-cycle read-data strobe
  rsp_rdata  out  8  read byte
  mem_we  out  1  RAM write strobe
  mem_byte_en  out  2  RAM lane enables; bit0 = [7:0], bit1 = [15:8]
  mem_addr  out  ADDR_W  RAM word address
  mem_data_in  out  16  RAM write data
  mem_data_out  in  16  RAM read data, valid one cycle after mem_addr (registered read)

Function
REQ-004 A request SHALL be accepted only on a rising edge where req_valid and req_ready are both 1.
REQ-005 All mem_* outputs, rsp_valid and rsp_rdata SHALL be registered.
REQ-006 The state machine SHALL have four states: IDLE, HOLD, RD_WAIT and RD_RESP.
REQ-007 In IDLE, req_ready SHALL be 1.
REQ-008 A write accepted in IDLE SHALL capture the word address, lane and byte, then move to HOLD with no RAM write yet.
REQ-009 In HOLD, a write to the other lane of the same word SHALL be accepted and merged into one write in the next cycle: mem_we=1, mem_byte_en=2'b11, both bytes in place. The state then SHALL return to IDLE.
REQ-010 In HOLD, any other request SHALL see req_ready=0 for one cycle; the pending single-lane write (mem_byte_en=2'b01 or 2'b10) SHALL be issued, and the state SHALL return to IDLE. This flush also covers same-lane rewrites and reads of the pending word.
REQ-011 In HOLD, after HOLD_CYC consecutive cycles without req_valid, the pending write SHALL be flushed as in REQ-010.
REQ-012 mem_we SHALL be a single-cycle pulse; mem_data_in SHALL place lane-0 data in [7:0] and lane-1 data in [15:8], with the non-enabled lane driven 0.
REQ-013 A read accepted at edge T SHALL drive mem_addr and mem_we=0 in cycle T+1, wait in RD_WAIT, and latch the addressed lane of mem_data_out in RD_RESP.
REQ-014 rsp_valid SHALL be 1 for exactly cycle T+3, and rsp_rdata SHALL hold its value until the next response.
REQ-015 req_ready SHALL be 0 in RD_WAIT and RD_RESP, allowing at most one read in flight.
REQ-016 Read-after-write ordering SHALL be preserved: a read never overtakes a pending write (REQ-010).
REQ-017 mem_addr SHALL wrap naturally at 2**ADDR_W; no range checking SHALL be performed.

Reset
REQ-018 While rst_n=0, the block SHALL set state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_we=0, mem_byte_en=0, mem_addr=0, mem_data_in=0, and clear the hold counter.
REQ-019 Reset asserted mid-operation SHALL discard any pending byte or in-flight read, with no RAM write and no response issued.
REQ-020 req_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-021 With BYTE_RAM_COALESCE_EN defined, HOLD and merging SHALL exist as in REQ-008 to REQ-011.
REQ-022 Without BYTE_RAM_COALESCE_EN, the HOLD state SHALL be absent, and every accepted write SHALL issue a single-lane write in the next cycle with req_ready staying 1.

Structure
REQ-023 The package byte_ram_pkg SHALL hold the state enum, the lane constants LANE0/LANE1, and the byte_en encodings BE_LO=2'b01, BE_HI=2'b10, BE_ALL=2'b11.
REQ-024 The block SHALL be a single module with no sub-module; the bench SHALL instantiate it alongside byte_enable_ram.

Verification
REQ-025 Scenario: write 0x34 @ byte 4, then 0x12 @ byte 5 back-to-back -> one mem_we pulse, addr=2, byte_en=2'b11, data_in=16'h1234; a read of byte 5 then returns 0x12.
REQ-026 Scenario: write 0xAB @ byte 6, then idle -> flush after 4 cycles with addr=3, byte_en=2'b01, data_in=16'h00AB.
REQ-027 Scenario: write 0x55 @ byte 2, then read byte 2 -> req_ready low one cycle, write byte_en=2'b01 issued first, then rsp_rdata=0x55 three cycles after read acceptance.
REQ-028 Scenario: write 0x11 @ byte 0, then write 0x22 @ byte 0 -> two separate byte_en=2'b01 writes, and memory word 0 = 16'h0022.
REQ-029 Scenario: rst_n low during HOLD -> no mem_we pulse, and all outputs at REQ-018 values.
REQ-030 Scenario: build without BYTE_RAM_COALESCE_EN; writes of bytes 4 and 5 -> two mem_we pulses with byte_en 2'b01 then 2'b10.

Source files
------------

// File: rtl/byte_ram_pkg.sv
// Shared types and lane helpers for byte_ram_master.
// The HOLD state exists only when BYTE_RAM_COALESCE_EN is defined.
package byte_ram_pkg;

`ifdef BYTE_RAM_COALESCE_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_e;
`endif

  localparam logic       LANE0   = 1'b0;
  localparam logic       LANE1   = 1'b1;
  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_ALL  = 2'b11;

  function automatic logic [1:0] lane_be(input logic lane);
    if (lane == LANE1) begin
      return BE_HI;
    end else begin
      return BE_LO;
    end
  endfunction

  // Byte placed in its lane, the other lane zero.
  function automatic logic [15:0] lane_data(input logic lane, input logic [7:0] b);
    if (lane == LANE1) begin
      return {b, 8'h00};
    end else begin
      return {8'h00, b};
    end
  endfunction

  function automatic logic [7:0] lane_pick(input logic lane, input logic [15:0] w);
    if (lane == LANE1) begin
      return w[15:8];
    end else begin
      return w[7:0];
    end
  endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// 16-bit word RAM with per-byte write enables and a registered read port.
module byte_enable_ram #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [1:0]        byte_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out
);

  logic [15:0] mem_r [2**ADDR_W];

  // Byte-lane writes into the array
  always_ff @(posedge clk) begin
    if (we && byte_en[0]) begin
      mem_r[addr][7:0] <= data_in[7:0];
    end
    if (we && byte_en[1]) begin
      mem_r[addr][15:8] <= data_in[15:8];
    end
  end

  // Registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= 16'h0000;
    end else begin
      data_out <= mem_r[addr];
    end
  end

endmodule

// File: rtl/byte_ram_master.sv
// Byte-request master for a 16-bit byte-enable RAM; pairs adjacent byte writes
// into one word write when BYTE_RAM_COALESCE_EN is defined.
module byte_ram_master
  import byte_ram_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int HOLD_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W:0]   req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              mem_we,
  output logic [1:0]        mem_byte_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data_in,
  input  logic [15:0]       mem_data_out
);

  state_e            state_r;
  state_e            state_s;
  logic              lane_r;
  logic [ADDR_W-1:0] req_word_s;
  logic              req_lane_s;
  logic              we_s;
  logic [1:0]        be_s;
  logic [ADDR_W-1:0] addr_s;
  logic [15:0]       data_s;
  logic              rsp_valid_s;
  logic [7:0]        rsp_rdata_s;

`ifdef BYTE_RAM_COALESCE_EN
  localparam int CNT_W = (HOLD_CYC <= 1) ? 1 : $clog2(HOLD_CYC);

  logic [CNT_W-1:0]  hold_cnt_r;
  logic [ADDR_W-1:0] pend_word_r;
  logic [7:0]        pend_byte_r;
  logic              mergeable_s;
  logic              timeout_s;

  assign mergeable_s = req_valid & req_write & (req_word_s == pend_word_r) & (req_lane_s != lane_r);
  assign timeout_s   = (hold_cnt_r == CNT_W'(HOLD_CYC - 1));
`endif

  assign req_word_s = req_addr[ADDR_W:1];
  assign req_lane_s = req_addr[0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid && !req_write) begin
          state_s = RD_WAIT;
`ifdef BYTE_RAM_COALESCE_EN
        end else if (req_valid) begin
          state_s = HOLD;
`endif
        end else begin
          state_s = IDLE;
        end
      end
`ifdef BYTE_RAM_COALESCE_EN
      // Any request (merged or not) or a timeout resolves the pending byte.
      HOLD: begin
        if (req_valid || timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
`endif
      RD_WAIT: state_s = RD_RESP;
      RD_RESP: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Handshake and next values of the registered outputs
  always_comb begin
    req_ready   = 1'b0;
    we_s        = 1'b0;
    be_s        = BE_NONE;
    addr_s      = mem_addr;
    data_s      = 16'h0000;
    rsp_valid_s = 1'b0;
    rsp_rdata_s = rsp_rdata;
    case (state_r)
      IDLE: begin
        req_ready = rst_n;
        if (req_valid) begin
          addr_s = req_word_s;
`ifndef BYTE_RAM_COALESCE_EN
          we_s   = req_write;
          be_s   = req_write ? lane_be(req_lane_s) : BE_NONE;
          data_s = req_write ? lane_data(req_lane_s, req_wdata) : 16'h0000;
`endif
        end else begin
          addr_s = mem_addr;
        end
      end
`ifdef BYTE_RAM_COALESCE_EN
      HOLD: begin
        req_ready = rst_n & mergeable_s;
        addr_s    = pend_word_r;
        if (mergeable_s) begin
          we_s   = 1'b1;
          be_s   = BE_ALL;
          data_s = lane_data(lane_r, pend_byte_r) | lane_data(req_lane_s, req_wdata);
        end else if (req_valid || timeout_s) begin
          we_s   = 1'b1;
          be_s   = lane_be(lane_r);
          data_s = lane_data(lane_r, pend_byte_r);
        end else begin
          we_s = 1'b0;
        end
      end
`endif
      RD_RESP: begin
        rsp_valid_s = 1'b1;
        rsp_rdata_s = lane_pick(lane_r, mem_data_out);
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // Registered RAM and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we      <= 1'b0;
      mem_byte_en <= 2'b00;
      mem_addr    <= '0;
      mem_data_in <= 16'h0000;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
    end else begin
      mem_we      <= we_s;
      mem_byte_en <= be_s;
      mem_addr    <= addr_s;
      mem_data_in <= data_s;
      rsp_valid   <= rsp_valid_s;
      rsp_rdata   <= rsp_rdata_s;
    end
  end

  // Request capture: lane for reads, pending byte for held writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r <= LANE0;
`ifdef BYTE_RAM_COALESCE_EN
      pend_word_r <= '0;
      pend_byte_r <= 8'h00;
`endif
    end else if (state_r == IDLE && req_valid) begin
      lane_r <= req_lane_s;
`ifdef BYTE_RAM_COALESCE_EN
      pend_word_r <= req_word_s;
      pend_byte_r <= req_wdata;
`endif
    end
  end

`ifdef BYTE_RAM_COALESCE_EN
  // Consecutive idle cycles spent in HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_r <= '0;
    end else if (state_r == HOLD && !req_valid && !timeout_s) begin
      hold_cnt_r <= hold_cnt_r + 1'b1;
    end else begin
      hold_cnt_r <= '0;
    end
  end
`endif

endmodule
